// File: rtl/u712_sdram_init_refresh.sv
// SDRAM power-up init sequencer and periodic auto-refresh requester for U712 chip RAM.
// Optional U712_REFRESH_BURST_EN: one REF_ACK grant drains every pending refresh back-to-back.
module u712_sdram_init_refresh #(
   parameter int          PWRUP_CYCLES   = 16000,
   parameter int          REF_INTERVAL   = 624,
   parameter int          TRP_CYCLES     = 2,
   parameter int          TRFC_CYCLES    = 6,
   parameter int          TMRD_CYCLES    = 2,
   parameter int          INIT_REFRESHES = 8,
   parameter logic [10:0] MODE_WORD      = 11'h020
) (
   input  logic        CLK80,
   input  logic        RESET,
   input  logic        REF_ACK,
   output logic        INIT_DONE,
   output logic        REF_REQ,
   output logic        CMD_ACTIVE,
   output logic        CMD_CLK_EN,
   output logic        CMD_CSn,
   output logic        CMD_RASn,
   output logic        CMD_CASn,
   output logic        CMD_WEn,
   output logic [1:0]  CMD_BANK,
   output logic [10:0] CMD_MA
);

   localparam int CW = $clog2(PWRUP_CYCLES + 1);
   localparam int IW = $clog2(REF_INTERVAL + 1);
   localparam int RW = $clog2(INIT_REFRESHES + 1);

   typedef enum logic [3:0] {
      ST_PWRUP, ST_PALL, ST_TRP, ST_INITREF, ST_ITRFC,
      ST_MRS, ST_TMRD, ST_IDLE, ST_REF, ST_RTRFC
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] icnt_q, icnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [2:0]    pend_q, pend_d;
   logic          init_done_q, init_done_d;
   logic          ref_req_q, ref_req_d;
   logic          active_q, active_d;
   logic          cke_q, cke_d;
   logic [3:0]    cmd_q, cmd_d;
   logic [1:0]    bank_q, bank_d;
   logic [10:0]   ma_q, ma_d;
   logic          tick;
   logic          grant;

   always_comb begin
      tick   = init_done_q && (icnt_q == IW'(REF_INTERVAL - 1));
      icnt_d = '0;
      if (init_done_q && !tick) icnt_d = icnt_q + 1'b1;

      grant = (state_q == ST_IDLE) && ref_req_q && REF_ACK;

      // A tick landing on the REF cycle cancels the decrement.
      pend_d = pend_q;
      if (tick && (state_q != ST_REF) && (pend_q != 3'd7)) pend_d = pend_q + 3'd1;
      else if (!tick && (state_q == ST_REF))               pend_d = pend_q - 3'd1;

      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         ST_PWRUP:   if (cnt_q == CW'(PWRUP_CYCLES - 1)) state_d = ST_PALL;
         ST_PALL:    state_d = ST_TRP;
         ST_TRP:     if (cnt_q == CW'(TRP_CYCLES - 1)) state_d = ST_INITREF;
         ST_INITREF: begin
            state_d = ST_ITRFC;
            rcnt_d  = rcnt_q + 1'b1;
         end
         ST_ITRFC: begin
            if (cnt_q == CW'(TRFC_CYCLES - 1))
               state_d = (rcnt_q == RW'(INIT_REFRESHES)) ? ST_MRS : ST_INITREF;
         end
         ST_MRS:     state_d = ST_TMRD;
         ST_TMRD:    if (cnt_q == CW'(TMRD_CYCLES - 1)) state_d = ST_IDLE;
         ST_IDLE:    if (grant) state_d = ST_REF;
         ST_REF:     state_d = ST_RTRFC;
         ST_RTRFC: begin
            if (cnt_q == CW'(TRFC_CYCLES - 1)) begin
`ifdef U712_REFRESH_BURST_EN
               state_d = (pend_d != 3'd0) ? ST_REF : ST_IDLE;
`else
               state_d = ST_IDLE;
`endif
            end
         end
         default:    state_d = ST_PWRUP;
      endcase

      cnt_d = cnt_q + 1'b1;
      if ((state_d != state_q) || (state_q == ST_IDLE)) cnt_d = '0;

      init_done_d = init_done_q || (state_d == ST_IDLE);
      ref_req_d   = init_done_q && (pend_q != 3'd0) && (state_q == ST_IDLE) && !grant;
      active_d    = (state_d != ST_IDLE);
      cke_d       = (state_d != ST_PWRUP) || (cnt_d == CW'(PWRUP_CYCLES - 1));

      // Command outputs are registered from the next state so they align with it.
      cmd_d  = 4'b0111;
      bank_d = 2'b00;
      ma_d   = '0;
      case (state_d)
         ST_PALL: begin
            cmd_d    = 4'b0010;
            ma_d[10] = 1'b1;
         end
         ST_INITREF, ST_REF: cmd_d = 4'b0001;
         ST_MRS: begin
            cmd_d = 4'b0000;
            ma_d  = MODE_WORD;
         end
         default: cmd_d = 4'b0111;
      endcase
   end

   always_ff @(posedge CLK80) begin
      if (RESET) begin
         state_q     <= ST_PWRUP;
         cnt_q       <= '0;
         icnt_q      <= '0;
         rcnt_q      <= '0;
         pend_q      <= 3'd0;
         init_done_q <= 1'b0;
         ref_req_q   <= 1'b0;
         active_q    <= 1'b1;
         cke_q       <= 1'b0;
         cmd_q       <= 4'b1111;
         bank_q      <= 2'b00;
         ma_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         icnt_q      <= icnt_d;
         rcnt_q      <= rcnt_d;
         pend_q      <= pend_d;
         init_done_q <= init_done_d;
         ref_req_q   <= ref_req_d;
         active_q    <= active_d;
         cke_q       <= cke_d;
         cmd_q       <= cmd_d;
         bank_q      <= bank_d;
         ma_q        <= ma_d;
      end
   end

   assign INIT_DONE  = init_done_q;
   assign REF_REQ    = ref_req_q;
   assign CMD_ACTIVE = active_q;
   assign CMD_CLK_EN = cke_q;
   assign CMD_CSn    = cmd_q[3];
   assign CMD_RASn   = cmd_q[2];
   assign CMD_CASn   = cmd_q[1];
   assign CMD_WEn    = cmd_q[0];
   assign CMD_BANK   = bank_q;
   assign CMD_MA     = ma_q;

endmodule
